// File: rtl/adc_scan_scheduler.sv
// Periodic scan sequencer for an 8-channel SPI ADC conversion engine.
// Walks the latched channel mask, requests conversions and returns tagged samples.
module adc_scan_scheduler #(
   parameter int NUM_CH         = 8,
   parameter int DATA_W         = 12,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic [31:0]               period,
   input  logic [NUM_CH-1:0]         channel_mask,
   input  logic                      conv_ready,
   output logic                      conv_start,
   output logic [$clog2(NUM_CH)-1:0] conv_channel,
   input  logic                      conv_done,
   input  logic [DATA_W-1:0]         conv_data,
   output logic                      sample_valid,
   output logic [$clog2(NUM_CH)-1:0] sample_channel,
   output logic [DATA_W-1:0]         sample_data,
   output logic                      scan_done,
   output logic                      overrun,
   output logic                      timeout_err,
   input  logic                      err_clr
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int IDX_W = CH_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_SELECT,
      S_ISSUE,
      S_WAIT_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [31:0]         r_cnt;
   logic [31:0]         w_period_m1;
   logic                w_tick;
   logic [NUM_CH-1:0]   r_mask;
   logic [NUM_CH-1:0]   w_mask_next;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_next;
   logic [IDX_W-1:0]    w_idx_after;
   logic [CH_W-1:0]     r_chan;
   logic [CH_W-1:0]     w_chan_next;
   logic [TO_W-1:0]     r_tcnt;
   logic [TO_W-1:0]     w_tcnt_next;
   logic [NUM_CH-1:0]   w_avail;
   logic                w_found;
   logic [CH_W-1:0]     w_sel;
   logic                w_conv_start;
   logic                w_scan_done;
   logic                w_capture;
   logic                w_timeout;
   logic                r_sample_valid;
   logic [CH_W-1:0]     r_sample_channel;
   logic [DATA_W-1:0]   r_sample_data;
   logic                r_overrun;
   logic                r_timeout_err;

   // A period of 0 behaves like 1, i.e. a tick on every enabled cycle.
   assign w_period_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;
   assign w_tick      = enable && (r_cnt == w_period_m1);
   assign w_idx_after = IDX_W'(r_chan) + IDX_W'(1);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_avail
         assign w_avail[gi] = r_mask[gi] && (r_idx <= IDX_W'(gi));
      end
   endgenerate

   // Lowest remaining channel wins; idx == NUM_CH leaves nothing available.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_avail[i]) begin
            w_found = 1'b1;
            w_sel   = CH_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_mask_next  = r_mask;
      w_idx_next   = r_idx;
      w_chan_next  = r_chan;
      w_tcnt_next  = r_tcnt;
      w_conv_start = 1'b0;
      w_scan_done  = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) w_state_next = S_WAIT_TICK;
         end
         S_WAIT_TICK: begin
            if (!enable) begin
               w_state_next = S_IDLE;
            end else if (w_tick) begin
               w_mask_next  = channel_mask;
               w_idx_next   = '0;
               w_state_next = S_SELECT;
            end
         end
         S_SELECT: begin
            // An exhausted scan still reports completion even if enable just dropped.
            if (!w_found) begin
               w_scan_done  = 1'b1;
               w_state_next = enable ? S_WAIT_TICK : S_IDLE;
            end else if (!enable) begin
               w_state_next = S_IDLE;
            end else begin
               w_chan_next  = w_sel;
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!enable) begin
               w_state_next = S_IDLE;
            end else if (conv_ready) begin
               w_conv_start = 1'b1;
               w_tcnt_next  = '0;
               w_state_next = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            // A done arriving on the expiry cycle still counts as a result.
            if (conv_done) begin
               w_capture    = 1'b1;
               w_idx_next   = w_idx_after;
               w_state_next = enable ? S_SELECT : S_IDLE;
            end else if (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               w_timeout    = 1'b1;
               w_idx_next   = w_idx_after;
               w_state_next = enable ? S_SELECT : S_IDLE;
            end else begin
               w_tcnt_next  = r_tcnt + TO_W'(1);
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt            <= '0;
         r_mask           <= '0;
         r_idx            <= '0;
         r_chan           <= '0;
         r_tcnt           <= '0;
         r_sample_valid   <= 1'b0;
         r_sample_channel <= '0;
         r_sample_data    <= '0;
         r_overrun        <= 1'b0;
         r_timeout_err    <= 1'b0;
      end else begin
         r_cnt          <= (!enable || w_tick) ? 32'd0 : r_cnt + 32'd1;
         r_mask         <= w_mask_next;
         r_idx          <= w_idx_next;
         r_chan         <= w_chan_next;
         r_tcnt         <= w_tcnt_next;
         r_sample_valid <= w_capture;
         if (w_capture) begin
            r_sample_channel <= r_chan;
            r_sample_data    <= conv_data;
         end
         if (w_tick && (r_state != S_WAIT_TICK)) r_overrun <= 1'b1;
         else if (err_clr)                       r_overrun <= 1'b0;
         if (w_timeout)    r_timeout_err <= 1'b1;
         else if (err_clr) r_timeout_err <= 1'b0;
      end
   end

   assign conv_start     = w_conv_start;
   assign conv_channel   = r_chan;
   assign scan_done      = w_scan_done;
   assign sample_valid   = r_sample_valid;
   assign sample_channel = r_sample_channel;
   assign sample_data    = r_sample_data;
   assign overrun        = r_overrun;
   assign timeout_err    = r_timeout_err;

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Sequences the 8-channel SPI ADC conversion engine on a programmable sample period.
- Walks an enabled-channel mask in ascending order and issues one conversion request per enabled channel.
- Returns each 12-bit result as a tagged sample pulse to downstream consumers (gyroscope integration, telemetry).
- Flags overrun when a period elapses mid-scan, and timeout when the engine fails to answer.

Parameters:
NUM_CH, 8, number of ADC channels; channel index width is clog2(NUM_CH)=3
DATA_W, 12, conversion result width
TIMEOUT_CYCLES, 1024, maximum clk cycles spent in WAIT_DONE before the conversion is abandoned

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; high runs periodic scans
period  in  32  clk cycles between scan starts; 0 is treated as 1
channel_mask  in  8  bit i set = convert channel i; latched at scan start
conv_ready  in  1  conversion engine idle and able to accept a request
conv_start  out  1  one-cycle request pulse
conv_channel  out  3  channel address; valid with conv_start, held until done/timeout
conv_done  in  1  one-cycle pulse, result valid
conv_data  in  12  result, sampled when conv_done=1
sample_valid  out  1  one-cycle pulse
sample_channel  out  3  channel of the current sample
sample_data  out  12  result of the current sample
scan_done  out  1  one-cycle pulse after the last enabled channel of a scan
overrun  out  1  sticky; set when a period tick arrives while not in WAIT_TICK
timeout_err  out  1  sticky; set on conversion timeout
err_clr  in  1  synchronous clear of both sticky flags; a same-cycle set wins

Behaviour:
Reset values:
- All outputs 0. State IDLE. Period counter 0. Latched mask 0. Channel index 0.

Period timer:
- Counts only while enable=1. Held at 0 while enable=0.
- tick asserts when count == max(period,1)-1. The counter wraps to 0 on that cycle.
- The first tick after enable rises therefore occurs max(period,1) cycles later.

State machine:
- IDLE: if enable=1, go to WAIT_TICK.
- WAIT_TICK: if enable=0, go to IDLE. On tick: latch channel_mask, set idx=0, go to SELECT.
- SELECT: find the lowest set bit at or above idx in the latched mask.
  - Found: set conv_channel to that bit, go to ISSUE.
  - None: pulse scan_done, go to WAIT_TICK (or IDLE if enable=0).
  - An all-zero mask gives scan_done in the cycle after the tick, with no conversions.
- ISSUE: wait for conv_ready=1. Then pulse conv_start for 1 cycle, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - On conv_done: register sample_channel=conv_channel and sample_data=conv_data. Pulse sample_valid the next cycle. Set idx = channel+1, go to SELECT.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no conv_done: set timeout_err. No sample_valid. Set idx = channel+1, go to SELECT.
  - If channel == NUM_CH-1, idx+1 means "none", so SELECT ends the scan (no wrap within a scan).

Latency:
- With conv_ready=1: tick at cycle T gives SELECT at T+1 and conv_start at T+2.
- conv_done at cycle D gives sample_valid at D+1.
- Back-to-back channels: next conv_start at D+2 at the earliest.

Boundary conditions:
- conv_done outside WAIT_DONE: ignored.
- conv_done in the same cycle as timeout expiry: treated as done. Sample emitted, no error.
- tick in any state other than WAIT_TICK: the tick is dropped and overrun is set. The current scan continues.
- enable falls mid-scan: the in-flight conversion completes or times out (and emits its sample if done). Remaining channels are abandoned, there is no scan_done pulse, and the next state is IDLE. If enable falls in ISSUE before conv_start is issued, go directly to IDLE.
- channel_mask changes mid-scan: no effect until the next scan start.
- period changes mid-count: takes effect immediately in the compare. If count is already ≥ new period-1, the counter wraps via natural 32-bit overflow; no tick until the compare matches.
- Asynchronous reset mid-operation: everything returns to reset values immediately. Any pending conv_done is ignored.

Test Plan:
- period=100, mask=8'b1001_1000, engine answers 5 cycles after conv_start with data=0x100+ch -> samples (3,0x103),(4,0x104),(7,0x107) in order, then scan_done; the scan repeats every 100 cycles; overrun=0.
- mask=8'h00, period=10 -> scan_done one cycle after each tick; conv_start never asserted.
- period=20, mask=8'hFF, engine latency 5 -> the scan exceeds 20 cycles, so overrun=1 at the first missed tick. Assert err_clr -> overrun=0, then re-set at the next miss.
- conv_done withheld for channel 2 (mask=8'h07) -> timeout_err=1 after 1024 WAIT_DONE cycles; samples only for ch0 and ch1; scan_done still pulses.
- enable dropped during the ch1 conversion (mask=8'h0F) -> ch1 sample emitted, no ch2/ch3 conv_start, no scan_done, state IDLE. Re-enable -> the first tick comes `period` cycles later.
- reset_n pulsed low during WAIT_DONE -> all outputs 0 asynchronously. A late conv_done after release yields no sample_valid.
